// File: rtl/char_mem_arbiter_if.sv
// CPU-side bus of the character/font memory arbiter.
// Handshake: the master pulses cpu_req for one cycle with cpu_we/cpu_addr/cpu_wdata valid;
// it is taken only while cpu_busy=0. A read completes with a one-cycle cpu_rvalid pulse,
// and cpu_rdata then holds the result until the next read completes.
interface char_mem_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_busy;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_busy,
    input  cpu_rvalid,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_busy,
    output cpu_rvalid,
    output cpu_rdata
  );
endinterface

// File: rtl/char_mem_arbiter.sv
// Time-slot arbiter for the shared text/font BRAM: two video fetches per 8-pixel cell
// (character code, then glyph row), remaining cycles serve one buffered CPU access.
module char_mem_arbiter #(
  parameter int COLS      = 80,
  parameter int ADDR_W    = 13,
  parameter int FONT_BASE = 2560
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic [9:0]        vid_xpos,
  input  logic [9:0]        vid_ypos,
  input  logic              vid_fetch,
  char_mem_arbiter_if.slave cpu,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        glyph,
  output logic              glyph_hl,
  output logic              glyph_load,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_RET  = 2'd3;

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_rdata;
  logic              r_fetch0;
  logic              r_fetch1;
  logic              r_hl_pend;
  logic [7:0]        r_glyph;
  logic              r_glyph_hl;
  logic              r_glyph_load;

  logic [2:0]        w_slot;
  logic              w_vid0;
  logic              w_vid1;
  logic              w_cpu_slot;
  logic              w_capture;
  logic [ADDR_W-1:0] w_char_addr;
  logic [ADDR_W-1:0] w_font_addr;
  logic [1:0]        w_state_nxt;
  logic              w_accept;

  assign w_slot = vid_xpos[2:0];

  // Slot 1 stays a video slot once slot 0 started a cell, even if vid_fetch has dropped.
  assign w_vid0     = vid_fetch && (w_slot == 3'd0);
  assign w_vid1     = (w_slot == 3'd1) && (vid_fetch || r_fetch0);
  assign w_cpu_slot = !(w_vid0 || w_vid1);
  assign w_capture  = (w_slot == 3'd2) && r_fetch1;

  assign w_char_addr = ADDR_W'(vid_xpos[9:3]) + ADDR_W'(COLS) * ADDR_W'(vid_ypos[9:4]);
  // Glyph table starts at code 32, so code*16 is rebased by 32*16 = 512.
  assign w_font_addr = ADDR_W'(FONT_BASE) + ADDR_W'({mem_rdata[6:0], vid_ypos[3:0]})
                       - ADDR_W'(512);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpu.cpu_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_cpu_slot) begin
          w_state_nxt = r_we ? ST_IDLE : ST_RD;
        end
      end
      ST_RD: begin
        w_state_nxt = ST_RET;
      end
      ST_RET: begin
        // cpu_busy is already low here, so a new request is taken.
        if (cpu.cpu_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_addr = r_addr;
    mem_we   = 1'b0;
    if (w_vid0) begin
      mem_addr = w_char_addr;
    end else if (w_vid1) begin
      mem_addr = w_font_addr;
    end else if (r_state == ST_PEND) begin
      mem_we = r_we;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 8'd0;
      r_rdata <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= cpu.cpu_we;
        r_addr  <= cpu.cpu_addr;
        r_wdata <= cpu.cpu_wdata;
      end
      if (r_state == ST_RD) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_fetch0     <= 1'b0;
      r_fetch1     <= 1'b0;
      r_hl_pend    <= 1'b0;
      r_glyph      <= 8'd0;
      r_glyph_hl   <= 1'b0;
      r_glyph_load <= 1'b0;
    end else begin
      r_fetch0     <= w_vid0;
      r_fetch1     <= w_vid1;
      r_glyph_load <= w_capture;
      if (w_vid1) begin
        r_hl_pend <= mem_rdata[7];
      end
      if (w_capture) begin
        r_glyph    <= mem_rdata;
        r_glyph_hl <= r_hl_pend;
      end
    end
  end

  assign mem_wdata      = r_wdata;
  assign glyph          = r_glyph;
  assign glyph_hl       = r_glyph_hl;
  assign glyph_load     = r_glyph_load;
  assign cpu.cpu_busy   = (r_state == ST_PEND) || (r_state == ST_RD);
  assign cpu.cpu_rvalid = (r_state == ST_RET);
  assign cpu.cpu_rdata  = r_rdata;
  assign o_dbg_state    = r_state;

endmodule
